mem_arbiter: RTL and testbench

- Sole owner of the byte-wide RAM/IO port.
- Arbitrates between the instruction-fetch line-fill requester and the load/store buffer requester.
- Serializes each request into per-byte RAM cycles, assembles little-endian results and returns a one-cycle done pulse.
- Sits between the core (IFetch/ICache, LSB) and the top-level RAM/IO bus.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus between the arbiter, its two requesters and the byte-wide RAM/IO port.
interface mem_arbiter_if #(
  parameter int unsigned LINE_BYTES = 16
);
  // RAM/IO side
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [31:0]             mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;
  // Instruction-fetch line fill
  logic                    if_en;
  logic [31:0]             if_addr;
  logic                    if_done;
  logic [LINE_BYTES*8-1:0] if_data;
  // Load/store buffer
  logic                    lsb_en;
  logic                    lsb_wr;
  logic [31:0]             lsb_addr;
  logic [2:0]              lsb_len;
  logic [31:0]             lsb_w_data;
  logic                    lsb_done;
  logic [31:0]             lsb_r_data;

  // Arbiter view
  modport slave (
    input  mem_din, io_buffer_full,
    input  if_en, if_addr,
    input  lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    output mem_dout, mem_a, mem_wr,
    output if_done, if_data,
    output lsb_done, lsb_r_data
  );

  // Requester / RAM view
  modport master (
    output mem_din, io_buffer_full,
    output if_en, if_addr,
    output lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    input  mem_dout, mem_a, mem_wr,
    input  if_done, if_data,
    input  lsb_done, lsb_r_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port owner: arbitrates line fills and LSB accesses and
// serializes each into per-byte RAM cycles with little-endian assembly.
module mem_arbiter #(
  parameter int unsigned LINE_BYTES = 16,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          rollback,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW  = $clog2(LINE_BYTES) + 1;
  localparam int unsigned LineW = LINE_BYTES * 8;

  typedef enum logic [1:0] {StIdle, StIfRd, StLsRd, StLsWr} state_e;

  state_e            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [CntW-1:0]   issue_q, issue_d;   // addresses issued (reads) / bytes written
  logic [CntW-1:0]   cap_q, cap_d;       // next byte to capture
  logic              primed_q, primed_d; // mem_din carries a requested byte
  logic [31:0]       wdata_q, wdata_d;
  logic [LineW-1:0]  line_q, line_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [LineW-1:0]  if_data_q, if_data_d;
  logic [31:0]       lsb_r_data_q, lsb_r_data_d;
  logic [31:0]       next_addr;
  logic              grant_stall;
  logic              next_stall;

  assign next_addr   = base_q + 32'(issue_q);
  assign grant_stall = bus.io_buffer_full && (bus.lsb_addr[17:16] == IO_BASE_HI);
  assign next_stall  = bus.io_buffer_full && (next_addr[17:16] == IO_BASE_HI);

  // Next-state and datapath: grant, byte issue/capture, write sequencing.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    issue_d      = issue_q;
    cap_d        = cap_q;
    primed_d     = primed_q;
    wdata_d      = wdata_q;
    line_d       = line_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    wr_d         = 1'b0;
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    if_data_d    = if_data_q;
    lsb_r_data_d = lsb_r_data_q;

    unique case (state_q)
      StIdle: begin
        // A done still high blocks grants so the finished requester can drop en.
        if (!if_done_q && !lsb_done_q) begin
          if (bus.lsb_en && bus.lsb_wr) begin
            // Stores are committed: granted even under rollback.
            state_d = StLsWr;
            base_d  = bus.lsb_addr;
            len_d   = CntW'(bus.lsb_len);
            wdata_d = bus.lsb_w_data;
            addr_d  = bus.lsb_addr;
            dout_d  = bus.lsb_w_data[7:0];
            if (grant_stall) begin
              issue_d = '0;
            end else begin
              wr_d    = 1'b1;
              issue_d = CntW'(1);
            end
          end else if (bus.lsb_en && !rollback) begin
            state_d  = StLsRd;
            base_d   = bus.lsb_addr;
            len_d    = CntW'(bus.lsb_len);
            addr_d   = bus.lsb_addr;
            issue_d  = CntW'(1);
            cap_d    = '0;
            primed_d = 1'b0;
            line_d   = '0;
          end else if (bus.if_en && !bus.lsb_en && !rollback) begin
            state_d  = StIfRd;
            base_d   = bus.if_addr;
            len_d    = CntW'(LINE_BYTES);
            addr_d   = bus.if_addr;
            issue_d  = CntW'(1);
            cap_d    = '0;
            primed_d = 1'b0;
            line_d   = '0;
          end
        end
      end

      StIfRd, StLsRd: begin
        if (rollback) begin
          state_d = StIdle;
        end else begin
          if (issue_q < len_q) begin
            addr_d  = next_addr;
            issue_d = issue_q + CntW'(1);
          end
          primed_d = 1'b1;
          if (primed_q) begin
            line_d[{cap_q, 3'b000} +: 8] = bus.mem_din;
            cap_d = cap_q + CntW'(1);
            if (cap_q == len_q - CntW'(1)) begin
              state_d = StIdle;
              if (state_q == StIfRd) begin
                if_done_d = 1'b1;
                if_data_d = line_d;
              end else begin
                lsb_done_d   = 1'b1;
                lsb_r_data_d = line_d[31:0];
              end
            end
          end
        end
      end

      StLsWr: begin
        if (issue_q == len_q) begin
          state_d    = StIdle;
          lsb_done_d = 1'b1;
        end else if (!next_stall) begin
          addr_d  = next_addr;
          dout_d  = wdata_q[{issue_q[1:0], 3'b000} +: 8];
          wr_d    = 1'b1;
          issue_d = issue_q + CntW'(1);
        end
      end
    endcase
  end

  // State register: synchronous reset wins, rdy=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      len_q        <= '0;
      issue_q      <= '0;
      cap_q        <= '0;
      primed_q     <= 1'b0;
      wdata_q      <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      wr_q         <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= '0;
      lsb_r_data_q <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      issue_q      <= issue_d;
      cap_q        <= cap_d;
      primed_q     <= primed_d;
      wdata_q      <= wdata_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      wr_q         <= wr_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_data_q    <= if_data_d;
      lsb_r_data_q <= lsb_r_data_d;
    end
  end

  assign bus.mem_a      = addr_q;
  assign bus.mem_dout   = dout_q;
  assign bus.mem_wr     = wr_q & rdy;  // never write while frozen
  assign bus.if_done    = if_done_q;
  assign bus.if_data    = if_data_q;
  assign bus.lsb_done   = lsb_done_q;
  assign bus.lsb_r_data = lsb_r_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte RAM model frozen by rdy.
module tb_mem_arbiter;
  localparam int unsigned LB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic rollback;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0]     exp_word_q[$];
  logic [LB*8-1:0] exp_line_q[$];
  logic [39:0]     exp_wr_q[$];

  // RAM preload port
  logic        pl_en = 1'b0;
  logic [17:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  ram [0:262143];

  mem_arbiter_if #(.LINE_BYTES(LB)) bus ();

  mem_arbiter #(
    .LINE_BYTES(LB),
    .IO_BASE_HI(2'b11)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .rollback(rollback),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // RAM model: registered read one cycle after the address, frozen with rdy.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (rdy) begin
      if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[17:0]];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [LB*8-1:0] line_of(input logic [17:0] base);
    logic [LB*8-1:0] l;
    for (int b = 0; b < LB; b++) l[b*8 +: 8] = pat(base + 18'(b));
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (bus.mem_a !== 32'h0 || bus.mem_dout !== 8'h0 || bus.mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus: got a=%h dout=%h wr=%b, want 0 0 0",
               bus.mem_a, bus.mem_dout, bus.mem_wr);
    end
    vectors++;
    if (bus.if_done !== 1'b0 || bus.lsb_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b%b, want 00", bus.if_done, bus.lsb_done);
    end
    vectors++;
    if (bus.if_data !== '0 || bus.lsb_r_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h, want 0 0", bus.if_data, bus.lsb_r_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    int n = 0;
    bit seen = 0;
    logic [31:0] e;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_addr = 32'h100; bus.lsb_len = 3'd4;
    exp_word_q.push_back(32'h44332211);
    tick();
    vectors++;
    if (bus.mem_a !== 32'h100 || bus.mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL load_grant: got a=%h wr=%b, want 100 0", bus.mem_a, bus.mem_wr);
    end
    while (n < 20) begin
      tick(); n++;
      if (bus.lsb_done === 1'b1) begin seen = 1; break; end
    end
    bus.lsb_en = 1'b0;
    vectors++;
    if (!seen || n != 5) begin
      miscompares++;
      $display("FAIL load_latency: got %0d cycles (seen=%0d), want 5", n, seen);
    end
    e = exp_word_q.pop_front();
    vectors++;
    if (bus.lsb_r_data !== e) begin
      miscompares++;
      $display("FAIL load_data: got %h, want %h", bus.lsb_r_data, e);
    end
    tick();
    vectors++;
    if (bus.lsb_done !== 1'b0) begin
      miscompares++;
      $display("FAIL load_pulse: got %b, want 0", bus.lsb_done);
    end
  endtask

  task automatic test_priority();
    int n = 0;
    bit seen = 0;
    logic [31:0] e;
    logic [LB*8-1:0] el;
    bus.if_en = 1'b1; bus.if_addr = 32'h1000;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_addr = 32'h104; bus.lsb_len = 3'd1;
    exp_word_q.push_back(32'h55);
    exp_line_q.push_back(line_of(18'h1000));
    tick();
    vectors++;
    if (bus.mem_a !== 32'h104) begin
      miscompares++;
      $display("FAIL prio_grant: got a=%h, want 104", bus.mem_a);
    end
    while (n < 10) begin
      tick(); n++;
      if (bus.lsb_done === 1'b1 || bus.if_done === 1'b1) begin seen = 1; break; end
    end
    bus.lsb_en = 1'b0;
    e = exp_word_q.pop_front();
    vectors++;
    if (!seen || n != 2 || bus.lsb_done !== 1'b1 || bus.if_done !== 1'b0 ||
        bus.lsb_r_data !== e) begin
      miscompares++;
      $display("FAIL prio_lsb: got n=%0d done=%b%b data=%h, want n=2 done=01 data=%h",
               n, bus.if_done, bus.lsb_done, bus.lsb_r_data, e);
    end
    tick();
    vectors++;
    if (bus.lsb_done !== 1'b0 || bus.mem_a !== 32'h104) begin
      miscompares++;
      $display("FAIL prio_gap: got done=%b a=%h, want 0 104", bus.lsb_done, bus.mem_a);
    end
    tick();
    vectors++;
    if (bus.mem_a !== 32'h1000) begin
      miscompares++;
      $display("FAIL prio_if_grant: got a=%h, want 1000", bus.mem_a);
    end
    n = 0; seen = 0;
    while (n < 40) begin
      tick(); n++;
      if (bus.if_done === 1'b1) begin seen = 1; break; end
    end
    bus.if_en = 1'b0;
    el = exp_line_q.pop_front();
    vectors++;
    if (!seen || n != 17 || bus.if_data !== el || bus.lsb_done !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_if_fill: got n=%0d data=%h, want n=17 data=%h", n, bus.if_data, el);
    end
    tick();
    vectors++;
    if (bus.if_done !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_if_pulse: got %b, want 0", bus.if_done);
    end
  endtask

  task automatic test_store_io();
    logic [39:0] e;
    bus.io_buffer_full = 1'b1;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_addr = 32'h30000; bus.lsb_len = 3'd1;
    bus.lsb_w_data = 32'hCCBBAA41;
    exp_wr_q.push_back({32'h30000, 8'h41});
    for (int s = 0; s < 3; s++) begin
      tick();
      vectors++;
      if (bus.mem_wr !== 1'b0 || bus.lsb_done !== 1'b0) begin
        miscompares++;
        $display("FAIL store_stall%0d: got wr=%b done=%b, want 0 0", s, bus.mem_wr, bus.lsb_done);
      end
    end
    bus.io_buffer_full = 1'b0;
    tick();
    e = exp_wr_q.pop_front();
    vectors++;
    if (bus.mem_wr !== 1'b1 || {bus.mem_a, bus.mem_dout} !== e) begin
      miscompares++;
      $display("FAIL store_write: got wr=%b a=%h d=%h, want 1 %h %h",
               bus.mem_wr, bus.mem_a, bus.mem_dout, e[39:8], e[7:0]);
    end
    tick();
    vectors++;
    if (bus.lsb_done !== 1'b1 || bus.mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL store_done: got done=%b wr=%b, want 1 0", bus.lsb_done, bus.mem_wr);
    end
    bus.lsb_en = 1'b0;
    tick();
  endtask

  task automatic test_rollback_fill();
    int n = 0;
    bit seen = 0;
    logic [LB*8-1:0] el;
    bus.if_en = 1'b1; bus.if_addr = 32'h2000;
    tick();
    repeat (6) tick();
    rollback = 1'b1; bus.if_en = 1'b0;
    tick();
    rollback = 1'b0;
    vectors++;
    if (bus.if_done !== 1'b0 || bus.mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL rb_fill_abort: got done=%b wr=%b, want 0 0", bus.if_done, bus.mem_wr);
    end
    bus.if_en = 1'b1;
    exp_line_q.push_back(line_of(18'h2000));
    tick();
    vectors++;
    if (bus.mem_a !== 32'h2000 || bus.if_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rb_fill_regrant: got a=%h done=%b, want 2000 0", bus.mem_a, bus.if_done);
    end
    while (n < 40) begin
      tick(); n++;
      if (bus.if_done === 1'b1) begin seen = 1; break; end
    end
    bus.if_en = 1'b0;
    el = exp_line_q.pop_front();
    vectors++;
    if (!seen || n != 17 || bus.if_data !== el) begin
      miscompares++;
      $display("FAIL rb_fill_refill: got n=%0d data=%h, want n=17 data=%h", n, bus.if_data, el);
    end
    tick();
  endtask

  task automatic test_rollback_store();
    int n = 0;
    bit seen = 0;
    logic [39:0] e;
    rollback = 1'b1;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_addr = 32'h200; bus.lsb_len = 3'd4;
    bus.lsb_w_data = 32'hDEADBEEF;
    exp_wr_q.push_back({32'h200, 8'hEF});
    exp_wr_q.push_back({32'h201, 8'hBE});
    exp_wr_q.push_back({32'h202, 8'hAD});
    exp_wr_q.push_back({32'h203, 8'hDE});
    tick();
    while (n < 20) begin
      if (bus.mem_wr === 1'b1) begin
        vectors++;
        if (exp_wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL rb_store_extra: got a=%h d=%h, want no write", bus.mem_a, bus.mem_dout);
        end else begin
          e = exp_wr_q.pop_front();
          if ({bus.mem_a, bus.mem_dout} !== e) begin
            miscompares++;
            $display("FAIL rb_store_byte: got a=%h d=%h, want %h %h",
                     bus.mem_a, bus.mem_dout, e[39:8], e[7:0]);
          end
        end
      end
      if (bus.lsb_done === 1'b1) begin seen = 1; break; end
      tick(); n++;
    end
    bus.lsb_en = 1'b0;
    vectors++;
    if (!seen || n != 4 || exp_wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL rb_store_done: got seen=%0d n=%0d left=%0d, want 1 4 0",
               seen, n, exp_wr_q.size());
    end
    tick();
    rollback = 1'b0;
    exp_wr_q.delete();
  endtask

  task automatic test_rdy_stall();
    int n = 0;
    bit seen = 0;
    logic [31:0] e;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_addr = 32'h300; bus.lsb_len = 3'd2;
    exp_word_q.push_back(32'h00005AA5);
    tick();
    tick(); n++;
    rdy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick(); n++;
      vectors++;
      if (bus.mem_wr !== 1'b0 || bus.lsb_done !== 1'b0 || bus.mem_a !== 32'h301) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got wr=%b done=%b a=%h, want 0 0 301",
                 s, bus.mem_wr, bus.lsb_done, bus.mem_a);
      end
    end
    rdy = 1'b1;
    while (n < 20) begin
      tick(); n++;
      if (bus.lsb_done === 1'b1) begin seen = 1; break; end
    end
    bus.lsb_en = 1'b0;
    e = exp_word_q.pop_front();
    vectors++;
    if (!seen || n != 5 || bus.lsb_r_data !== e) begin
      miscompares++;
      $display("FAIL stall_result: got n=%0d data=%h, want n=5 data=%h", n, bus.lsb_r_data, e);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    bus.if_en = 1'b1; bus.if_addr = 32'h1000;
    tick();
    repeat (4) tick();
    rst = 1'b1; bus.if_en = 1'b0;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.mem_a !== 32'h0 || bus.mem_dout !== 8'h0 || bus.mem_wr !== 1'b0 ||
        bus.if_done !== 1'b0 || bus.lsb_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_bus: got a=%h d=%h wr=%b done=%b%b, want all 0",
               bus.mem_a, bus.mem_dout, bus.mem_wr, bus.if_done, bus.lsb_done);
    end
    vectors++;
    if (bus.if_data !== '0 || bus.lsb_r_data !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_data: got %h %h, want 0 0", bus.if_data, bus.lsb_r_data);
    end
    repeat (20) begin
      tick();
      if (bus.if_done === 1'b1 || bus.lsb_done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL midrst_quiet: got %0d done cycles, want 0", dones);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.if_en = 1'b0; bus.if_addr = '0;
    bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0; bus.lsb_len = '0;
    bus.lsb_w_data = '0;
    for (int b = 0; b < LB; b++) begin
      poke(18'h1000 + 18'(b), pat(18'h1000 + 18'(b)));
      poke(18'h2000 + 18'(b), pat(18'h2000 + 18'(b)));
    end
    poke(18'h100, 8'h11); poke(18'h101, 8'h22); poke(18'h102, 8'h33); poke(18'h103, 8'h44);
    poke(18'h104, 8'h55);
    poke(18'h300, 8'hA5); poke(18'h301, 8'h5A);

    test_reset();
    test_load();
    test_priority();
    test_store_io();
    test_rollback_fill();
    test_rollback_store();
    test_rdy_stall();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
